mem_access_stage: RTL

- MEM stage of the 5-stage pipeline. It consumes the EX/MEM pipeline register outputs, performs load/store through a request/acknowledge data-memory port, and produces the MEM/WB pipeline register.
- Memory latency is variable. While an access is outstanding the stage holds upstream stages with `stall`.
- Misaligned accesses and memory timeouts are detected and reported.

---
 rtl/mem_access_stage.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage.
// Takes the EX/MEM register, runs loads and stores over a req/ack data-memory
// port with variable latency, and produces the MEM/WB register. While an access
// is outstanding, upstream stages are held with `stall`. A misaligned access is
// dropped and flagged. A memory that never acknowledges is aborted after
// TIMEOUT cycles, and the abort sets a sticky bus error.
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  WB,
    input  logic [2:0]  MEMOut,
    input  logic [31:0] ALUOut,
    input  logic [31:0] WriteDataIn,
    input  logic [4:0]  regRD,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [1:0]  WBOut,
    output logic [31:0] ReadDataOut,
    output logic [31:0] ALUResultOut,
    output logic [4:0]  RegRDOut,
    output logic        align_error,
    output logic        bus_error
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    // MEM/WB pipeline register contents
    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
    } memwb_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    memwb_t           memwb;

    logic access, misaligned, at_limit;

    // Branch is resolved earlier in the pipe; this stage does not use it.
    logic unused_branch;
    assign unused_branch = MEMOut[2];

    assign access     = MEMOut[1] | MEMOut[0];
    assign misaligned = access & (ALUOut[1:0] != 2'b00);
    assign at_limit   = (cnt == LIMIT);

    assign WBOut        = memwb.wb;
    assign ReadDataOut  = memwb.rdata;
    assign ALUResultOut = memwb.alu;
    assign RegRDOut     = memwb.rd;

    // Hold upstream from the request cycle until the ack or abort cycle.
    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            if (state == IDLE) stall = access & ~misaligned;
            else               stall = ~dmem_ack & ~at_limit;
        end
    end

    // A bubble keeps the data fields but kills the writeback controls.
    function automatic memwb_t bubble(input logic [31:0] alu, input logic [4:0] rd);
        memwb_t m;
        m.wb    = 2'b00;
        m.rdata = 32'h0;
        m.alu   = alu;
        m.rd    = rd;
        return m;
    endfunction

    // Access FSM, memory port registers and MEM/WB register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= 32'h0;
            dmem_wdata  <= 32'h0;
            memwb       <= '0;
            align_error <= 1'b0;
            bus_error   <= 1'b0;
        end else begin
            align_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (!access) begin
                        memwb.wb    <= WB;
                        memwb.rdata <= 32'h0;
                        memwb.alu   <= ALUOut;
                        memwb.rd    <= regRD;
                    end else if (misaligned) begin
                        memwb       <= bubble(ALUOut, regRD);
                        align_error <= 1'b1;
                    end else begin
                        // When both MemRead and MemWrite are set, the access is a store.
                        state      <= BUSY;
                        cnt        <= '0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= MEMOut[0];
                        dmem_addr  <= {ALUOut[31:2], 2'b00};
                        dmem_wdata <= WriteDataIn;
                        memwb      <= bubble(ALUOut, regRD);
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        // An ack wins over a timeout in the same cycle.
                        state       <= IDLE;
                        dmem_req    <= 1'b0;
                        memwb.wb    <= WB;
                        memwb.rdata <= dmem_we ? 32'h0 : dmem_rdata;
                        memwb.alu   <= ALUOut;
                        memwb.rd    <= regRD;
                    end else if (at_limit) begin
                        state     <= IDLE;
                        dmem_req  <= 1'b0;
                        bus_error <= 1'b1;
                        memwb     <= bubble(ALUOut, regRD);
                    end else begin
                        cnt   <= cnt + 1'b1;
                        memwb <= bubble(ALUOut, regRD);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
